// File: rtl/approx_mult_pipe_if.sv
// Streaming handshake bundle for approx_mult_pipe.
// Ports: in_valid/in_ready/in_a/in_b/in_mode (request), out_valid/out_ready/out_p/out_mode (result).
`timescale 1ns/1ps
interface approx_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 out_mode;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_p, out_mode
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_p, out_mode
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// 3-stage pipelined recursive multiplier with per-transaction exact/LOA-approximate recombination.
// Ports: clk, rst (async, active-high), bus (approx_mult_pipe_if.slave);
// with APPROX_ERR_MON_EN defined also err_count[31:0] and err_max[2*WIDTH-1:0].
`timescale 1ns/1ps
module approx_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    approx_mult_pipe_if.slave   bus
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [31:0]         err_count,
    output logic [2*WIDTH-1:0]  err_max
`endif
);
    localparam int H = WIDTH / 2;
    localparam int K = APPROX_BITS;
    localparam int OW = 3 * H;

    // Lower-part-OR adder for the middle sum; keeps the carry out.
    function automatic logic [WIDTH:0] loa_mid(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             approx
    );
        logic [WIDTH:0] xe, ye, lo_mask;
        xe      = {1'b0, x};
        ye      = {1'b0, y};
        lo_mask = ({{WIDTH{1'b0}}, 1'b1} << K) - 1'b1;
        if (!approx || K == 0)
            return xe + ye;
        return (((xe >> K) + (ye >> K)) << K) | ((xe | ye) & lo_mask);
    endfunction

    // Same adder for the final recombination; carry out is dropped.
    function automatic logic [OW-1:0] loa_out(
        input logic [OW-1:0] x,
        input logic [OW-1:0] y,
        input logic          approx
    );
        logic [OW-1:0] lo_mask;
        lo_mask = ({{(OW-1){1'b0}}, 1'b1} << K) - 1'b1;
        if (!approx || K == 0)
            return x + y;
        return (((x >> K) + (y >> K)) << K) | ((x | y) & lo_mask);
    endfunction

    logic                s1_valid, s2_valid, s3_valid;
    logic [H-1:0]        s1_ah, s1_al, s1_bh, s1_bl;
    logic                s1_mode, s2_mode, s3_mode;
    logic [WIDTH-1:0]    s2_p1, s2_p4;
    logic [WIDTH:0]      s2_mid;
    logic [2*WIDTH-1:0]  s3_p;

    logic [WIDTH-1:0]    p1, p2, p3, p4;
    logic [WIDTH:0]      mid;
    logic [OW-1:0]       op1, sum;
    logic                s1_load, s2_load, s3_load;

    // Each stage loads when empty or when its content leaves this cycle.
    assign s3_load = !s3_valid || bus.out_ready;
    assign s2_load = !s2_valid || s3_load;
    assign s1_load = !s1_valid || s2_load;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s3_valid;
    assign bus.out_p     = s3_p;
    assign bus.out_mode  = s3_mode;

    assign p1  = WIDTH'(s1_ah) * WIDTH'(s1_bh);
    assign p2  = WIDTH'(s1_ah) * WIDTH'(s1_bl);
    assign p3  = WIDTH'(s1_al) * WIDTH'(s1_bh);
    assign p4  = WIDTH'(s1_al) * WIDTH'(s1_bl);
    assign mid = loa_mid(p2, p3, s1_mode);

    assign op1 = {s2_p1, s2_p4[WIDTH-1:H]};
    assign sum = loa_out(op1, {{(H-1){1'b0}}, s2_mid}, s2_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_ah    <= '0;
            s1_al    <= '0;
            s1_bh    <= '0;
            s1_bl    <= '0;
            s1_mode  <= 1'b0;
            s2_p1    <= '0;
            s2_p4    <= '0;
            s2_mid   <= '0;
            s2_mode  <= 1'b0;
            s3_p     <= '0;
            s3_mode  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_ah   <= bus.in_a[WIDTH-1:H];
                    s1_al   <= bus.in_a[H-1:0];
                    s1_bh   <= bus.in_b[WIDTH-1:H];
                    s1_bl   <= bus.in_b[H-1:0];
                    s1_mode <= bus.in_mode;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_p1   <= p1;
                    s2_p4   <= p4;
                    s2_mid  <= mid;
                    s2_mode <= s1_mode;
                end
            end
            if (s3_load) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_p    <= {sum, s2_p4[H-1:0]};
                    s3_mode <= s2_mode;
                end
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [2*WIDTH-1:0] s1_ex, s2_ex, s3_ex;
    logic [2*WIDTH-1:0] abs_err;
    logic               out_fire;

    assign out_fire = s3_valid && bus.out_ready;
    assign abs_err  = (s3_ex > s3_p) ? (s3_ex - s3_p) : (s3_p - s3_ex);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ex     <= '0;
            s2_ex     <= '0;
            s3_ex     <= '0;
            err_count <= '0;
            err_max   <= '0;
        end else begin
            if (s1_load && bus.in_valid)
                s1_ex <= (2*WIDTH)'(bus.in_a) * (2*WIDTH)'(bus.in_b);
            if (s2_load && s1_valid)
                s2_ex <= s1_ex;
            if (s3_load && s2_valid)
                s3_ex <= s2_ex;
            if (out_fire) begin
                if (s3_p != s3_ex && err_count != 32'hFFFF_FFFF)
                    err_count <= err_count + 32'd1;
                if (abs_err > err_max)
                    err_max <= abs_err;
            end
        end
    end
`endif
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed steps with randomized data
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_approx_mult_pipe;
    localparam int W = 8;
    localparam int H = W / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_mult_pipe_if #(.WIDTH(W)) ifc ();
    approx_mult_pipe_if #(.WIDTH(W)) ifc0 ();

`ifdef APPROX_ERR_MON_EN
    logic [31:0]    ec, ec0;
    logic [2*W-1:0] em, em0;
    longint         mc, mm;
`endif

    approx_mult_pipe #(.WIDTH(W), .APPROX_BITS(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_count(ec),
        .err_max(em)
`endif
    );

    approx_mult_pipe #(.WIDTH(W), .APPROX_BITS(0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(ifc0)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_count(ec0),
        .err_max(em0)
`endif
    );

    typedef struct {
        logic [2*W-1:0] p;
        logic           m;
        logic [2*W-1:0] ex;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Adder rule: exact sum, or OR on the low k bits and a carry-isolated
    // sum above them; result kept to n bits.
    function automatic longint loa(input longint x, input longint y,
                                   input int n, input int k, input logic m);
        longint r;
        if (!m || k == 0)
            r = x + y;
        else
            r = (((x >> k) + (y >> k)) << k) + ((x | y) & ((64'sd1 << k) - 1));
        return r & ((64'sd1 << n) - 1);
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic m, input int k);
        longint ah, al, bh, bl, p1, p2, p3, p4, mid, op1, o;
        ah  = longint'(a) >> H;
        al  = longint'(a) % (1 << H);
        bh  = longint'(b) >> H;
        bl  = longint'(b) % (1 << H);
        p1  = ah * bh;
        p2  = ah * bl;
        p3  = al * bh;
        p4  = al * bl;
        mid = loa(p2, p3, W + 1, k, m);
        op1 = p1 * (1 << H) + (p4 >> H);
        o   = loa(op1, mid, 3 * H + 1, k, m) % (64'sd1 << (3 * H));
        return (2*W)'(o * (1 << H) + p4 % (1 << H));
    endfunction

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic m, input int k);
        exp_t e;
        e.p  = model(a, b, m, k);
        e.m  = m;
        e.ex = (2*W)'(longint'(a) * longint'(b));
        return e;
    endfunction

    // One clock: record handshakes just before the edge, then return
    // 1 time unit after the edge so new stimulus can be applied.
    task automatic cycle(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = ifc.in_valid && ifc.in_ready;
        if (acc)
            q.push_back(mk(ifc.in_a, ifc.in_b, ifc.in_mode, 2));
        if (ifc0.in_valid && ifc0.in_ready)
            q0.push_back(mk(ifc0.in_a, ifc0.in_b, ifc0.in_mode, 0));
        if (ifc.out_valid && ifc.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", ifc.out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_p", ifc.out_p, e.p);
                chk("out_mode", ifc.out_mode, e.m);
`ifdef APPROX_ERR_MON_EN
                if (e.p != e.ex) mc++;
                if (longint'(e.ex) - longint'(e.p) > mm)
                    mm = longint'(e.ex) - longint'(e.p);
                if (longint'(e.p) - longint'(e.ex) > mm)
                    mm = longint'(e.p) - longint'(e.ex);
`endif
            end
        end
        if (ifc0.out_valid && ifc0.out_ready) begin
            if (q0.size() == 0) begin
                chk("unexpected_out0", ifc0.out_valid, 0);
            end else begin
                e = q0.pop_front();
                chk("out_p_exact", ifc0.out_p, e.ex);
                chk("out_mode0", ifc0.out_mode, e.m);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int idx, cyc, n, first_stall_q;
        bit saw_stall;

        rst            = 1'b1;
        ifc.in_valid   = 1'b0;
        ifc.in_a       = '0;
        ifc.in_b       = '0;
        ifc.in_mode    = 1'b0;
        ifc.out_ready  = 1'b0;
        ifc0.in_valid  = 1'b0;
        ifc0.in_a      = '0;
        ifc0.in_b      = '0;
        ifc0.in_mode   = 1'b0;
        ifc0.out_ready = 1'b1;
`ifdef APPROX_ERR_MON_EN
        mc = 0;
        mm = 0;
`endif

        // Reset state
        #12;
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_p", ifc.out_p, 0);
        chk("rst_out_mode", ifc.out_mode, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Exact FF*FF with latency check
        ifc.in_valid  = 1'b1;
        ifc.in_a      = 8'hFF;
        ifc.in_b      = 8'hFF;
        ifc.in_mode   = 1'b0;
        ifc.out_ready = 1'b1;
        cycle(acc);
        ifc.in_valid = 1'b0;
        chk("t1_accept", acc, 1);
        chk("t1_lat1", ifc.out_valid, 0);
        cycle(acc);
        chk("t1_lat2", ifc.out_valid, 0);
        cycle(acc);
        chk("t1_lat3", ifc.out_valid, 1);
        chk("t1_p", ifc.out_p, 16'hFE01);
        chk("t1_mode", ifc.out_mode, 0);
        cycle(acc);

        // Approximate 11*11
        ifc.in_valid = 1'b1;
        ifc.in_a     = 8'h11;
        ifc.in_b     = 8'h11;
        ifc.in_mode  = 1'b1;
        cycle(acc);
        ifc.in_valid = 1'b0;
        cycle(acc);
        cycle(acc);
        chk("t2_valid", ifc.out_valid, 1);
        chk("t2_p", ifc.out_p, 16'h0111);
        chk("t2_mode", ifc.out_mode, 1);
        cycle(acc);
`ifdef APPROX_ERR_MON_EN
        chk("t2_err_count", ec, 1);
        chk("t2_err_max", em, 16'h0010);
`endif

        // Streaming with backpressure window
        idx = 0;
        cyc = 0;
        saw_stall = 0;
        first_stall_q = -1;
        ifc.in_a    = 8'($urandom);
        ifc.in_b    = 8'($urandom);
        ifc.in_mode = 1'b0;
        while (idx < 20 && cyc < 200) begin
            ifc.in_valid  = 1'b1;
            ifc.out_ready = !(cyc >= 5 && cyc <= 9);
            cycle(acc);
            if (acc) begin
                idx++;
                ifc.in_a    = 8'($urandom);
                ifc.in_b    = 8'($urandom);
                ifc.in_mode = idx[0];
            end else if (!saw_stall) begin
                saw_stall = 1;
                first_stall_q = q.size();
            end
            cyc++;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        chk("t3_accepted", idx, 20);
        chk("t3_stall_seen", saw_stall, 1);
        chk("t3_inflight_at_stall", first_stall_q, 3);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        chk("t3_drained", q.size(), 0);

        // APPROX_BITS=0 instance in approximate mode is always exact
        for (int i = 0; i < 2004; i++) begin
            ifc0.in_valid = 1'b1;
            ifc0.in_mode  = 1'b1;
            case (i)
                0: begin ifc0.in_a = 8'h00; ifc0.in_b = 8'h00; end
                1: begin ifc0.in_a = 8'hFF; ifc0.in_b = 8'hFF; end
                2: begin ifc0.in_a = 8'hFF; ifc0.in_b = 8'h01; end
                3: begin ifc0.in_a = 8'h0F; ifc0.in_b = 8'hF0; end
                default: begin
                    ifc0.in_a = 8'($urandom);
                    ifc0.in_b = 8'($urandom);
                end
            endcase
            cycle(acc);
        end
        ifc0.in_valid = 1'b0;
        n = 0;
        while (q0.size() != 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        chk("t4_drained", q0.size(), 0);
`ifdef APPROX_ERR_MON_EN
        chk("t4_err_count", ec0, 0);
        chk("t4_err_max", em0, 0);
        chk("mon_err_count", ec, mc);
        chk("mon_err_max", em, mm);
`endif

        // Async reset with 3 in flight
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_a     = 8'($urandom);
            ifc.in_b     = 8'($urandom);
            ifc.in_mode  = i[0];
            cycle(acc);
        end
        ifc.in_valid = 1'b0;
        chk("t5_full_valid", ifc.out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", ifc.out_valid, 0);
        chk("t5_rst_p", ifc.out_p, 0);
        q.delete();
`ifdef APPROX_ERR_MON_EN
        chk("t5_rst_err_count", ec, 0);
        mc = 0;
        mm = 0;
`endif
        #1;
        rst = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_a     = 8'd3;
        ifc.in_b     = 8'd5;
        ifc.in_mode  = 1'b0;
        cycle(acc);
        ifc.in_valid = 1'b0;
        chk("t5_accept", acc, 1);
        chk("t5_lat1", ifc.out_valid, 0);
        cycle(acc);
        chk("t5_lat2", ifc.out_valid, 0);
        cycle(acc);
        chk("t5_valid", ifc.out_valid, 1);
        chk("t5_p", ifc.out_p, 15);
        cycle(acc);
        cycle(acc);
        chk("t5_no_stale", ifc.out_valid, 0);

        // Output hold under backpressure
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_a      = 8'($urandom);
        ifc.in_b      = 8'($urandom);
        ifc.in_mode   = 1'b1;
        cycle(acc);
        ifc.in_valid = 1'b0;
        n = 0;
        while (!ifc.out_valid && n < 10) begin
            cycle(acc);
            n++;
        end
        chk("t6_valid", ifc.out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            chk("t6_hold_valid", ifc.out_valid, 1);
            chk("t6_hold_p", ifc.out_p, (q.size() != 0) ? q[0].p : 16'hxxxx);
            chk("t6_hold_mode", ifc.out_mode, (q.size() != 0) ? q[0].m : 1'bx);
        end
        ifc.out_ready = 1'b1;
        cycle(acc);
        chk("t6_single", ifc.out_valid, 0);
        chk("t6_drained", q.size(), 0);
`ifdef APPROX_ERR_MON_EN
        chk("t6_err_count", ec, mc);
        chk("t6_err_max", em, mm);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
